// File: rtl/fetch_dispatch.sv
// Instruction fetch/decode/dispatch sequencer: reads an 18-bit ROM word, hands MOV/ALU
// work to an execute unit, waits for done under a 4-bit watchdog, then retires.
module fetch_dispatch (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [17:0] instr_data,
  input  logic        done,
  output logic [7:0]  pc,
  output logic        rom_en,
  output logic [5:0]  opcode,
  output logic [5:0]  parameter1,
  output logic [5:0]  parameter2,
  output logic        start_mov,
  output logic        start_alu,
  output logic        donefetch,
  output logic        halted,
  output logic        err_illegal,
  output logic        err_timeout
);

  localparam int unsigned PC_W = 8;
  localparam int unsigned OP_W = 6;
  localparam int unsigned WD_W = 4;

  localparam logic [WD_W-1:0] WD_MAX = WD_W'(15);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_RETIRE = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [OP_W-1:0] OP_MOV  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ALU1 = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ALU2 = OP_W'(2);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(63);

  logic [2:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic [OP_W-1:0] r_opcode;
  logic [OP_W-1:0] r_param1;
  logic [OP_W-1:0] r_param2;
  logic [WD_W-1:0] r_wd;
  logic            r_start_mov;
  logic            r_start_alu;
  logic            r_donefetch;
  logic            r_halted;
  logic            r_err_illegal;
  logic            r_err_timeout;

  logic [2:0]      w_state_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  logic [WD_W-1:0] w_wd_nxt;
  logic            w_ir_load;
  logic            w_start_mov_nxt;
  logic            w_start_alu_nxt;
  logic            w_donefetch_nxt;
  logic            w_halted_nxt;
  logic            w_illegal_set;
  logic            w_timeout_set;
  logic            w_rom_en;

  // Next-state and registered-output decode; start_* and donefetch are set on entry to their state.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_wd_nxt        = r_wd;
    w_ir_load       = 1'b0;
    w_start_mov_nxt = 1'b0;
    w_start_alu_nxt = 1'b0;
    w_donefetch_nxt = 1'b0;
    w_halted_nxt    = r_halted;
    w_illegal_set   = 1'b0;
    w_timeout_set   = 1'b0;
    w_rom_en        = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (run) begin
          w_rom_en    = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_ir_load   = 1'b1;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (r_opcode)
          OP_MOV: begin
            w_state_nxt     = S_EXEC;
            w_start_mov_nxt = 1'b1;
            w_wd_nxt        = '0;
          end
          OP_ALU1, OP_ALU2: begin
            w_state_nxt     = S_EXEC;
            w_start_alu_nxt = 1'b1;
            w_wd_nxt        = '0;
          end
          OP_HALT: begin
            w_state_nxt  = S_HALT;
            w_halted_nxt = 1'b1;
          end
          default: begin
            w_illegal_set   = 1'b1;
            w_donefetch_nxt = 1'b1;
            w_state_nxt     = S_RETIRE;
          end
        endcase
      end
      S_EXEC: begin
        // done wins over an expiring watchdog in the same cycle
        if (done) begin
          w_state_nxt     = S_RETIRE;
          w_donefetch_nxt = 1'b1;
        end else if (r_wd == WD_MAX) begin
          w_timeout_set   = 1'b1;
          w_state_nxt     = S_RETIRE;
          w_donefetch_nxt = 1'b1;
        end else begin
          w_wd_nxt        = r_wd + WD_W'(1);
          w_start_mov_nxt = r_start_mov;
          w_start_alu_nxt = r_start_alu;
        end
      end
      S_RETIRE: begin
        w_pc_nxt    = r_pc + PC_W'(1);
        w_state_nxt = S_FETCH;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // State, program counter, instruction register and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_pc          <= '0;
      r_opcode      <= '0;
      r_param1      <= '0;
      r_param2      <= '0;
      r_wd          <= '0;
      r_start_mov   <= 1'b0;
      r_start_alu   <= 1'b0;
      r_donefetch   <= 1'b0;
      r_halted      <= 1'b0;
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_wd        <= w_wd_nxt;
      r_start_mov <= w_start_mov_nxt;
      r_start_alu <= w_start_alu_nxt;
      r_donefetch <= w_donefetch_nxt;
      r_halted    <= w_halted_nxt;
      if (w_ir_load) begin
        r_opcode <= instr_data[17:12];
        r_param1 <= instr_data[11:6];
        r_param2 <= instr_data[5:0];
      end
      if (w_illegal_set) r_err_illegal <= 1'b1;
      if (w_timeout_set) r_err_timeout <= 1'b1;
    end
  end

  // ROM strobe follows run in FETCH so the first fetch lands in the first run cycle.
  assign rom_en      = w_rom_en & ~rst;
  assign pc          = r_pc;
  assign opcode      = r_opcode;
  assign parameter1  = r_param1;
  assign parameter2  = r_param2;
  assign start_mov   = r_start_mov;
  assign start_alu   = r_start_alu;
  assign donefetch   = r_donefetch;
  assign halted      = r_halted;
  assign err_illegal = r_err_illegal;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_fetch_dispatch.sv
// Randomized bench for fetch_dispatch: a synchronous ROM model plus an instruction-level
// reference model that predicts every output on every cycle.
module tb_fetch_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [17:0] instr_data;
  logic        done;
  logic [7:0]  pc;
  logic        rom_en;
  logic [5:0]  opcode;
  logic [5:0]  parameter1;
  logic [5:0]  parameter2;
  logic        start_mov;
  logic        start_alu;
  logic        donefetch;
  logic        halted;
  logic        err_illegal;
  logic        err_timeout;

  fetch_dispatch dut (
    .clk(clk), .rst(rst), .run(run), .instr_data(instr_data), .done(done),
    .pc(pc), .rom_en(rom_en), .opcode(opcode), .parameter1(parameter1),
    .parameter2(parameter2), .start_mov(start_mov), .start_alu(start_alu),
    .donefetch(donefetch), .halted(halted), .err_illegal(err_illegal),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  logic [17:0] rom [256];

  // Synchronous program ROM read on the strobe.
  always @(posedge clk) if (rom_en) instr_data <= rom[pc];

  int checks = 0;
  int errors = 0;

  logic [7:0] m_pc;
  logic [5:0] m_op, m_p1, m_p2;
  logic       m_ill, m_to;

  function automatic logic [32:0] obs();
    return {pc, rom_en, start_mov, start_alu, donefetch, halted,
            err_illegal, err_timeout, opcode, parameter1, parameter2};
  endfunction

  function automatic logic [17:0] rand_instr();
    int k;
    logic [5:0] op;
    k = $urandom_range(0, 3);
    if (k == 3) op = 6'($urandom_range(3, 62));
    else        op = 6'(k);
    return {op, 6'($urandom), 6'($urandom)};
  endfunction

  task automatic model_clear();
    m_pc = 8'd0; m_op = 6'd0; m_p1 = 6'd0; m_p2 = 6'd0; m_ill = 1'b0; m_to = 1'b0;
  endtask

  // One full instruction from FETCH; done_cyc is the EXEC cycle (1-based) carrying done, 0 = never.
  task automatic exec_instr(input string name, input int done_cyc, input int n_idle);
    logic [17:0] ins;
    logic [5:0]  op;
    logic [32:0] exp_v;
    bit          is_mov, is_alu, is_halt, is_ill, tmo;
    int          n_exec, total;
    ins     = rom[m_pc];
    op      = ins[17:12];
    is_mov  = (op == 6'd0);
    is_alu  = (op == 6'd1) || (op == 6'd2);
    is_halt = (op == 6'd63);
    is_ill  = !(is_mov || is_alu || is_halt);
    tmo     = (is_mov || is_alu) && (done_cyc < 1 || done_cyc > 16);
    n_exec  = (is_mov || is_alu) ? (tmo ? 16 : done_cyc) : 0;
    total   = is_halt ? 23 : 4 + n_exec;
    for (int i = 0; i < n_idle; i++) begin
      @(negedge clk);
      run  = 1'b0;
      done = 1'($urandom_range(0, 1));
      #1;
      exp_v = {m_pc, 5'b00000, m_ill, m_to, m_op, m_p1, m_p2};
      checks++;
      if (obs() !== exp_v)
        $display("FAIL %s idle%0d: got %h want %h", name, i, obs(), exp_v);
      if (obs() !== exp_v) errors++;
    end
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      run = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (c >= 3 && c < 3 + n_exec) done = (c - 2 == done_cyc);
      else                          done = 1'($urandom_range(0, 1));
      if (c == 2) {m_op, m_p1, m_p2} = ins;
      if (!is_halt && c == total - 1) begin
        m_ill = m_ill | is_ill;
        m_to  = m_to | tmo;
      end
      #1;
      exp_v = {m_pc, (c == 0),
               is_mov && c >= 3 && c < 3 + n_exec,
               is_alu && c >= 3 && c < 3 + n_exec,
               !is_halt && c == total - 1,
               is_halt && c >= 3,
               m_ill, m_to, m_op, m_p1, m_p2};
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL %s pc%0d cyc%0d: got %h want %h", name, m_pc, c, obs(), exp_v);
      end
    end
    if (!is_halt) m_pc = m_pc + 8'd1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst  = 1'b1;
    run  = 1'b1;
    done = 1'b1;
    model_clear();
    #1;
    checks++;
    if (obs() !== 33'd0) begin
      errors++;
      $display("FAIL reset: got %h want %h", obs(), 33'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
  endtask

  task automatic test_directed();
    test_reset();
    rom[0] = 18'b000000_000010_000001;
    rom[1] = {6'd1, 6'd5, 6'd9};
    rom[2] = {6'd7, 6'd3, 6'd4};
    rom[3] = {6'd63, 6'd0, 6'd0};
    exec_instr("mov", 3, 2);
    exec_instr("alu", 2, 0);
    exec_instr("illegal", 1, 1);
    exec_instr("halt", 1, 0);
  endtask

  task automatic test_timeout();
    test_reset();
    rom[0] = {6'd0, 6'd1, 6'd2};
    rom[1] = {6'd0, 6'd3, 6'd4};
    rom[2] = {6'd2, 6'd5, 6'd6};
    rom[3] = {6'd1, 6'd7, 6'd8};
    exec_instr("done_at_wd15", 16, 0);
    exec_instr("timeout_mov", 0, 0);
    exec_instr("timeout_alu", 17, 0);
    exec_instr("after_timeout", 1, 0);
  endtask

  task automatic test_random_wrap();
    test_reset();
    for (int i = 0; i < 256; i++) rom[i] = rand_instr();
    for (int i = 0; i < 262; i++)
      exec_instr("random", $urandom_range(0, 18), $urandom_range(0, 2));
  endtask

  task automatic test_reset_mid_exec();
    test_reset();
    rom[0] = {6'd0, 6'($urandom), 6'($urandom)};
    @(negedge clk); run = 1'b1; done = 1'b0;
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (start_mov !== 1'b1) begin
      errors++;
      $display("FAIL mid_exec_start: got %b want 1", start_mov);
    end
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (obs() !== 33'd0) begin
      errors++;
      $display("FAIL mid_exec_reset: got %h want %h", obs(), 33'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    exec_instr("refetch", 2, 1);
  endtask

  initial begin
    rst  = 1'b1;
    run  = 1'b0;
    done = 1'b0;
    model_clear();
    test_directed();
    test_timeout();
    test_random_wrap();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_dispatch.md
FETCH_DISPATCH -- requirements
Module: fetch_dispatch

Interface
REQ-001 The block SHALL have one clock and asynchronous active-high reset; clock and reset ports are `clk` and `rst`.
REQ-002 Ports SHALL be, as name  direction  width  meaning:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- run  in  1  enables instruction fetch
- instr_data  in  18  program ROM word: [17:12] opcode, [11:6] parameter1, [5:0] parameter2
- done  in  1  completion from the selected execute unit
- pc  out  8  program counter / ROM address
- rom_en  out  1  ROM read strobe
- opcode  out  6  latched opcode
- parameter1  out  6  latched destination field
- parameter2  out  6  latched source field
- start_mov  out  1  MOV unit start, level
- start_alu  out  1  ALU unit start, level
- donefetch  out  1  one-cycle retire pulse; returns execute units to their idle state
- halted  out  1  processor halted
- err_illegal  out  1  sticky illegal-opcode flag
- err_timeout  out  1  sticky execute-timeout flag

Function
REQ-003 The state machine SHALL have these states: FETCH, LOAD, DECODE, EXEC, RETIRE, HALT.
REQ-004 FETCH SHALL behave as follows:
- With run=1: rom_en=1, go to LOAD next cycle.
- With run=0: hold FETCH with rom_en=0.
REQ-005 LOAD SHALL capture instr_data into the instruction register (opcode, parameter1, parameter2) on the clock edge leaving LOAD, then go to DECODE.
REQ-006 DECODE SHALL dispatch on the opcode:
- 000000: MOV, go to EXEC.
- 000001 or 000010: ALU, go to EXEC.
- 111111: go to HALT.
- Any other value: set err_illegal, go to RETIRE.
REQ-007 In EXEC, start_mov (MOV) or start_alu (ALU) SHALL be held at 1 every cycle; both SHALL never be 1 together.
REQ-008 EXEC SHALL exit as follows:
- done=1 sampled on an edge: go to RETIRE.
- Otherwise the 4-bit watchdog (cleared on EXEC entry) increments each EXEC cycle.
- Watchdog reaching 15 without done: set err_timeout, go to RETIRE.
- Watchdog SHALL not wrap.
REQ-009 RETIRE SHALL last exactly one cycle:
- donefetch=1, start_* = 0.
- pc increments modulo 256 (255 -> 0).
- Next state FETCH.
REQ-010 HALT SHALL be terminal until reset: halted=1, pc frozen, rom_en=0, no donefetch.
REQ-011 opcode, parameter1 and parameter2 SHALL hold their last captured values from LOAD until the next LOAD.
REQ-012 done asserted outside EXEC SHALL be ignored.
REQ-013 done and watchdog=15 in the same cycle SHALL count as success: no err_timeout.
REQ-014 run dropping outside FETCH SHALL not abort the current instruction; the block stops at the next FETCH.
REQ-015 err_illegal and err_timeout SHALL stay set until reset and SHALL not stop execution.
REQ-016 Minimum MOV latency is FETCH→LOAD→DECODE→EXEC (≥1 cycle)→RETIRE; with done returned on the 3rd EXEC cycle, one instruction takes 7 cycles.

Reset
REQ-017 When rst=1, at any time including mid-EXEC, the block SHALL asynchronously force:
- state to FETCH.
- pc, opcode, parameter1, parameter2, and watchdog to 0.
- start_mov, start_alu, rom_en, donefetch, halted, err_illegal, and err_timeout to 0.
REQ-018 After rst is released, the first rom_en SHALL occur in the first cycle with run=1.

Verification
REQ-019 MOV: ROM[0]=000000_000010_000001, run=1, done pulsed on 3rd EXEC cycle -> start_mov high 3 cycles, parameter1=2, parameter2=1, one donefetch pulse, pc=1.
REQ-020 ALU: ROM[1]=000001_… -> start_alu high, start_mov=0 throughout, pc=2 after RETIRE.
REQ-021 Illegal: ROM[2]=000111_… -> err_illegal=1, no start_* pulse, donefetch pulse, pc=3, next fetch proceeds.
REQ-022 Timeout: MOV with done held 0 -> after watchdog reaches 15, err_timeout=1, donefetch pulse; done together with watchdog=15 -> err_timeout stays 0.
REQ-023 Halt/wrap: ROM[3]=111111_… -> halted=1, pc stays 3 for ≥20 cycles; separately, preload pc=255 via NOPs -> pc wraps to 0.
REQ-024 Reset mid-EXEC: rst pulse during start_mov=1 -> all outputs 0 immediately, pc=0, refetch from address 0.
